// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its requester arbiter.
//   ALU_*         : alucontrol encodings understood by the alu
//   alu_op_valid  : 1 when an alucontrol code is one of the defined operations
//   arb_state_e   : arbiter state encoding
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } arb_state_e;

    function automatic logic alu_op_valid(input logic [2:0] op);
        logic ok;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: ok = 1'b1;
            default:                                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle 32-bit combinational ALU.
//   a, b        : operands
//   alucontrol  : operation select (AND, OR, ADD, SUB, unsigned SLT)
//   result      : operation result; 0 for undefined codes
//   zero        : result == 0
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alucontrol,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (alucontrol)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {31'b0, (a < b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one alu among NREQ requesters.
// One operation in flight: accept (IDLE) -> execute (EXEC) -> respond (RESP).
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   req_valid    : per-requester request pending
//   req_ready    : one-hot accept pulse, only in IDLE
//   req_a/req_b  : packed 32-bit operands, requester i at [32i+31:32i]
//   req_op       : packed 3-bit alucontrol codes, requester i at [3i+2:3i]
//   resp_valid   : one-hot owner of the registered response
//   resp_ready   : per-requester response consume; only the owner's bit matters
//   resp_result  : registered ALU result
//   resp_zero    : registered zero flag
//   resp_err     : op code was undefined
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*3-1:0]    req_op,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          resp_result,
    output logic                 resp_zero,
    output logic                 resp_err
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Reset "last" to the top index so requester 0 wins the first grant.
    localparam logic [IdxW-1:0] LastInit = IdxW'(NREQ - 1);

    // Rotate so the search starts at last+1, take the lowest set bit, rotate back.
    function automatic logic [IdxW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                                input logic [IdxW-1:0] last_idx);
        logic [2*NREQ-1:0] dbl;
        logic [NREQ-1:0]   rot;
        int unsigned       start;
        int unsigned       off;
        int unsigned       sum;
        logic              found;
        start = 32'(last_idx) + 1;
        if (start >= NREQ) start = start - NREQ;
        dbl   = {valid, valid};
        rot   = NREQ'(dbl >> start);
        off   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                off   = i;
                found = 1'b1;
            end
        end
        sum = start + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return IdxW'(sum);
    endfunction

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] last_q;
    logic [IdxW-1:0] grant_q;
    logic [31:0]     opa_q, opb_q;
    logic [2:0]      op_q;
    logic [31:0]     result_q;
    logic            zero_q, err_q;

    logic [IdxW-1:0] pick;
    logic            accept;
    logic            release_resp;
    logic [31:0]     alu_result;
    logic            alu_zero;

    assign pick = rr_pick(req_valid, last_q);

    alu u_alu (
        .a          (opa_q),
        .b          (opb_q),
        .alucontrol (op_q),
        .result     (alu_result),
        .zero       (alu_zero)
    );

    always_comb begin
        state_d      = state_q;
        req_ready    = '0;
        resp_valid   = '0;
        accept       = 1'b0;
        release_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Gate on reset so req_ready reads 0 while reset is held.
                if (!reset && (|req_valid)) begin
                    req_ready = NREQ'(1) << pick;
                    accept    = 1'b1;
                    state_d   = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                resp_valid = NREQ'(1) << grant_q;
                if (resp_ready[grant_q]) begin
                    release_resp = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            last_q   <= LastInit;
            grant_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q <= pick;
                opa_q   <= req_a[{pick, 5'd0} +: 32];
                opb_q   <= req_b[{pick, 5'd0} +: 32];
                op_q    <= req_op[3 * 32'(pick) +: 3];
            end
            if (state_q == StExec) begin
                if (alu_op_valid(op_q)) begin
                    result_q <= alu_result;
                    zero_q   <= alu_zero;
                    err_q    <= 1'b0;
                end else begin
                    result_q <= '0;
                    zero_q   <= 1'b1;
                    err_q    <= 1'b1;
                end
            end
            if (release_resp) begin
                last_q <= grant_q;
            end
        end
    end

    assign resp_result = result_q;
    assign resp_zero   = zero_q;
    assign resp_err    = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // NREQ=4 instance
    logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [N*32-1:0] req_a, req_b;
    logic [N*3-1:0]  req_op;
    logic [31:0]     resp_result;
    logic            resp_zero, resp_err;

    logic [31:0] ta  [N];
    logic [31:0] tbv [N];
    logic [2:0]  tops[N];

    always_comb begin
        req_a  = '0;
        req_b  = '0;
        req_op = '0;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = ta[i];
            req_b[32*i +: 32] = tbv[i];
            req_op[3*i +: 3]  = tops[i];
        end
    end

    alu_share_arbiter #(.NREQ(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err)
    );

    // NREQ=2 instance (default width)
    logic [1:0]  r2_valid, r2_ready, r2_resp_valid, r2_resp_ready;
    logic [63:0] r2_a, r2_b;
    logic [5:0]  r2_op;
    logic [31:0] r2_result;
    logic        r2_zero, r2_err;

    alu_share_arbiter #(.NREQ(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (r2_valid),
        .req_ready   (r2_ready),
        .req_a       (r2_a),
        .req_b       (r2_b),
        .req_op      (r2_op),
        .resp_valid  (r2_resp_valid),
        .resp_ready  (r2_resp_ready),
        .resp_result (r2_result),
        .resp_zero   (r2_zero),
        .resp_err    (r2_err)
    );

    int checks   = 0;
    int failures = 0;
    int last_g;   // model: last served requester of the NREQ=4 instance

    // Reference: next requester after 'last' (cyclically) that is valid.
    function automatic int model_pick(input logic [N-1:0] v, input int last, input int n);
        for (int k = 1; k <= n; k++) begin
            int idx;
            idx = (last + k) % n;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Reference ALU: returns {err, zero, result}.
    function automatic logic [33:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        logic [31:0] r;
        logic        e;
        e = 1'b0;
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a + b;
            3'b110:  r = a - b;
            3'b111:  r = (a < b) ? 32'd1 : 32'd0;
            default: begin r = 32'd0; e = 1'b1; end
        endcase
        return {e, (r == 32'd0), r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        reset      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        r2_valid   = '0;
        last_g     = N - 1;
    endtask

    // One full transaction on the NREQ=4 instance: grant, EXEC, RESP held 'hold' cycles.
    task automatic do_txn(input logic [N-1:0] vmask, input int hold, input string tag);
        int          g;
        logic [33:0] exp;
        logic [N-1:0] oh;
        req_valid = vmask;
        #1;
        g  = model_pick(vmask, last_g, N);
        oh = '0;
        oh[g] = 1'b1;
        checks++;
        if (req_ready !== oh) begin
            failures++;
            $display("FAIL %s grant: req_ready=%b expected %b", tag, req_ready, oh);
        end
        exp = model_alu(ta[g], tbv[g], tops[g]);
        step();
        // Operands must already be captured; scramble the live inputs.
        for (int i = 0; i < N; i++) begin
            ta[i]   = $urandom;
            tbv[i]  = $urandom;
            tops[i] = 3'($urandom);
        end
        checks++;
        if (req_ready !== '0 || resp_valid !== '0) begin
            failures++;
            $display("FAIL %s exec: req_ready=%b resp_valid=%b expected 0/0",
                     tag, req_ready, resp_valid);
        end
        step();
        for (int h = 0; h <= hold; h++) begin
            resp_ready = N'($urandom) & ~oh;
            checks++;
            if (resp_valid !== oh || resp_result !== exp[31:0] || resp_zero !== exp[32] ||
                resp_err !== exp[33] || req_ready !== '0) begin
                failures++;
                $display("FAIL %s resp[%0d]: valid=%b res=%h z=%b e=%b rdy=%b expected %b %h %b %b 0",
                         tag, h, resp_valid, resp_result, resp_zero, resp_err, req_ready,
                         oh, exp[31:0], exp[32], exp[33]);
            end
            if (h == hold) resp_ready = resp_ready | oh;
            step();
        end
        resp_ready = '0;
        last_g     = g;
        checks++;
        if (resp_valid !== '0) begin
            failures++;
            $display("FAIL %s release: resp_valid=%b expected 0", tag, resp_valid);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b1111;
        step();
        step();
        checks++;
        if (req_ready !== '0 || resp_valid !== '0 || resp_result !== '0 ||
            resp_zero !== 1'b0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset: rdy=%b val=%b res=%h z=%b e=%b expected all 0",
                     req_ready, resp_valid, resp_result, resp_zero, resp_err);
        end
        reset     = 1'b0;
        req_valid = '0;
        last_g    = N - 1;
        #1;
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL idle_no_valid: req_ready=%b expected 0", req_ready);
        end
    endtask

    task automatic test_basic();
        ta[0] = 32'd5; tbv[0] = 32'd3; tops[0] = 3'b010;
        do_txn(4'b0001, 0, "basic_add");
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ta[0] = 32'd7; tbv[0] = 32'd7; tops[0] = 3'b110;
            ta[1] = 32'd1; tbv[1] = 32'd2; tops[1] = 3'b111;
            do_txn(4'b0011, 0, "round_robin");
        end
    endtask

    task automatic test_bad_op();
        ta[1] = $urandom; tbv[1] = $urandom; tops[1] = 3'b100;
        do_txn(4'b0010, 0, "bad_op");
    endtask

    task automatic test_hold();
        ta[0] = 32'hFFFF0000; tbv[0] = 32'h00FF00FF; tops[0] = 3'b001;
        ta[1] = 32'h12345678; tbv[1] = 32'h0F0F0F0F; tops[1] = 3'b000;
        do_txn(4'b0011, 10, "hold");
        ta[0] = 32'd9; tbv[0] = 32'd4; tops[0] = 3'b110;
        ta[1] = 32'd9; tbv[1] = 32'd4; tops[1] = 3'b111;
        do_txn(4'b0011, 0, "after_hold");
    endtask

    task automatic test_reset_mid();
        ta[2] = 32'd5; tbv[2] = 32'd3; tops[2] = 3'b010;
        do_txn(4'b0100, 0, "pre_reset");
        req_valid = 4'b0011;
        step();                 // accepted, now in EXEC
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0 || resp_valid !== '0 || resp_result !== '0 ||
            resp_zero !== 1'b0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: rdy=%b val=%b res=%h z=%b e=%b expected all 0",
                     req_ready, resp_valid, resp_result, resp_zero, resp_err);
        end
        step();
        reset     = 1'b0;
        req_valid = '0;
        last_g    = N - 1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (resp_valid !== '0) begin
                failures++;
                $display("FAIL reset_mid_after[%0d]: resp_valid=%b expected 0", c, resp_valid);
            end
            step();
        end
        ta[0] = 32'd3; tbv[0] = 32'd3; tops[0] = 3'b010;
        ta[1] = 32'd3; tbv[1] = 32'd3; tops[1] = 3'b110;
        do_txn(4'b0011, 0, "first_after_reset");
    endtask

    task automatic test_nreq4();
        do_reset();
        ta[1] = 32'hA5A5A5A5; tbv[1] = 32'h0000FFFF; tops[1] = 3'b000;
        ta[3] = 32'd0;        tbv[3] = 32'd1;        tops[3] = 3'b110;
        do_txn(4'b1010, 0, "n4_first");
        ta[1] = 32'hA5A5A5A5; tbv[1] = 32'h0000FFFF; tops[1] = 3'b000;
        ta[3] = 32'd0;        tbv[3] = 32'd1;        tops[3] = 3'b110;
        do_txn(4'b1010, 0, "n4_sub_wrap");
        ta[1] = 32'hFFFFFFFF; tbv[1] = 32'd1; tops[1] = 3'b010;
        do_txn(4'b1010, 0, "n4_third");
    endtask

    task automatic test_random();
        logic [2:0] op_tab [8];
        op_tab = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
        for (int t = 0; t < 80; t++) begin
            logic [N-1:0] vm;
            if ($urandom_range(0, 4) == 0) begin
                req_valid = '0;
                for (int c = 0; c < int'($urandom_range(1, 2)); c++) begin
                    #1;
                    checks++;
                    if (req_ready !== '0 || resp_valid !== '0) begin
                        failures++;
                        $display("FAIL rand_idle: req_ready=%b resp_valid=%b expected 0/0",
                                 req_ready, resp_valid);
                    end
                    step();
                end
            end
            for (int i = 0; i < N; i++) begin
                ta[i]   = $urandom;
                tbv[i]  = ($urandom_range(0, 3) == 0) ? ta[i] : $urandom;
                tops[i] = op_tab[$urandom_range(0, 7)];
            end
            vm = N'($urandom);
            if (vm == '0) vm = 4'b0001 << $urandom_range(0, N - 1);
            do_txn(vm, int'($urandom_range(0, 3)), "random");
        end
    endtask

    // NREQ=2 instance: continuous valid, resp_ready tied high -> grants 0,1,0,1 every 3 cycles.
    task automatic test_nreq2();
        int          last2;
        logic [33:0] exp;
        logic [1:0]  oh;
        do_reset();
        last2         = 1;
        r2_a          = {32'd1, 32'd7};
        r2_b          = {32'd2, 32'd7};
        r2_op         = {3'b111, 3'b110};
        r2_resp_ready = 2'b11;
        r2_valid      = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            int g;
            g = model_pick({2'b00, r2_valid}, last2, 2);
            oh = '0;
            oh[g] = 1'b1;
            exp = model_alu(r2_a[32*g +: 32], r2_b[32*g +: 32], r2_op[3*g +: 3]);
            checks++;
            if (r2_ready !== oh) begin
                failures++;
                $display("FAIL n2_grant[%0d]: req_ready=%b expected %b", k, r2_ready, oh);
            end
            step();
            step();
            checks++;
            if (r2_resp_valid !== oh || r2_result !== exp[31:0] || r2_zero !== exp[32] ||
                r2_err !== exp[33] || r2_ready !== 2'b00) begin
                failures++;
                $display("FAIL n2_resp[%0d]: valid=%b res=%h z=%b e=%b rdy=%b expected %b %h %b %b 00",
                         k, r2_resp_valid, r2_result, r2_zero, r2_err, r2_ready,
                         oh, exp[31:0], exp[32], exp[33]);
            end
            step();
            last2 = g;
        end
        r2_valid      = '0;
        r2_resp_ready = '0;
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = '0;
        resp_ready    = '0;
        r2_valid      = '0;
        r2_resp_ready = '0;
        r2_a          = '0;
        r2_b          = '0;
        r2_op         = '0;
        for (int i = 0; i < N; i++) begin
            ta[i]   = '0;
            tbv[i]  = '0;
            tops[i] = '0;
        end
        last_g = N - 1;
        #1;
        test_reset();
        test_basic();
        test_round_robin();
        test_bad_op();
        test_hold();
        test_reset_mid();
        test_nreq4();
        test_random();
        test_nreq2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
